buyruk_kuyrugu: RTL

- Instruction queue between the front-end fetch stage and the decode stage (coz).
- Takes the front end's sticky valid/instruction/PC outputs and turns them into a clean valid/ready FIFO stream for decode.
- Drives the front end's stall input `gc_hazir` and its redirect request inputs (`bb_buy_istek`, `bb_buy_istek_adres`).
- On a pipeline redirect it flushes its contents and holds the redirect until the front end accepts it.

---
 rtl/buyruk_kuyrugu_pkg.sv | 12 +
 rtl/buyruk_kuyrugu_if.sv | 33 +++
 rtl/buyruk_kuyrugu_bellek.sv | 25 ++
 rtl/buyruk_kuyrugu.sv | 119 +++++++++++
 4 files changed

// File: rtl/buyruk_kuyrugu_pkg.sv
// Shared constants for the fetch-to-decode instruction queue.
package buyruk_kuyrugu_pkg;

    localparam int KB_DERINLIK   = 4;   // queue depth in entries
    localparam int KB_BUYRUK_BIT = 32;  // instruction width
    localparam int KB_ADRES_BIT  = 32;  // instruction address width

    // Slots kept free so the instruction the front end still presents
    // after the stall drops has somewhere to land.
    localparam int KB_AYRILMIS_YER = 2;

endpackage

// File: rtl/buyruk_kuyrugu_if.sv
// Decode-side stream of the instruction queue.
// Handshake: a head entry transfers in every cycle where coz_gecerli_c and
// coz_hazir_g are both high at the rising clock edge; coz_buy_c/coz_ps_c are
// meaningful only while coz_gecerli_c is high, and coz_gecerli_c does not
// depend on coz_hazir_g.
interface buyruk_kuyrugu_if
    import buyruk_kuyrugu_pkg::*;
#(
    parameter int BUYRUK_BIT = KB_BUYRUK_BIT,
    parameter int ADRES_BIT  = KB_ADRES_BIT
) ();

    logic                  coz_gecerli_c;
    logic [BUYRUK_BIT-1:0] coz_buy_c;
    logic [ADRES_BIT-1:0]  coz_ps_c;
    logic                  coz_hazir_g;

    // The queue drives the stream, decode consumes it.
    modport master (
        output coz_gecerli_c,
        output coz_buy_c,
        output coz_ps_c,
        input  coz_hazir_g
    );

    modport slave (
        input  coz_gecerli_c,
        input  coz_buy_c,
        input  coz_ps_c,
        output coz_hazir_g
    );

endinterface

// File: rtl/buyruk_kuyrugu_bellek.sv
// Queue storage: one write port, one asynchronous read port, no reset.
module buyruk_kuyrugu_bellek #(
    parameter int DERINLIK = 4,
    parameter int GENISLIK = 64
) (
    input  logic                        clk_g,
    input  logic                        yaz_en,
    input  logic [$clog2(DERINLIK)-1:0] yaz_adr,
    input  logic [GENISLIK-1:0]         yaz_veri,
    input  logic [$clog2(DERINLIK)-1:0] oku_adr,
    output logic [GENISLIK-1:0]         oku_veri
);

    logic [GENISLIK-1:0] mem_q [DERINLIK];

    // Write the addressed entry; contents are don't-care until written.
    always_ff @(posedge clk_g) begin
        if (yaz_en) begin
            mem_q[yaz_adr] <= yaz_veri;
        end
    end

    assign oku_veri = mem_q[oku_adr];

endmodule

// File: rtl/buyruk_kuyrugu.sv
// Instruction queue between fetch and decode: turns the front end's sticky
// valid/instruction outputs into a valid/ready stream, drives the front-end
// stall, and holds a back-end redirect until the front end takes it.
module buyruk_kuyrugu
    import buyruk_kuyrugu_pkg::*;
#(
    parameter int DERINLIK   = KB_DERINLIK,
    parameter int BUYRUK_BIT = KB_BUYRUK_BIT,
    parameter int ADRES_BIT  = KB_ADRES_BIT
) (
    input  logic                  clk_g,
    input  logic                  rst_n_g,
    input  logic                  on_buy_gecerli_g,
    input  logic [BUYRUK_BIT-1:0] on_buy_g,
    input  logic [ADRES_BIT-1:0]  on_buy_ps_g,
    output logic                  gc_hazir_c,
    output logic                  bb_buy_istek_c,
    output logic [ADRES_BIT-1:0]  bb_buy_istek_adres_c,
    input  logic                  yonlendir_g,
    input  logic [ADRES_BIT-1:0]  yonlendir_adres_g,
    buyruk_kuyrugu_if.master      coz
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = PW + 1;
    localparam int GW = BUYRUK_BIT + ADRES_BIT;

    logic [CW-1:0]        doluluk_q, doluluk_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic                 hazir_onceki_q, hazir_onceki_d;
    logic                 istek_bekliyor_q, istek_bekliyor_d;
    logic [ADRES_BIT-1:0] istek_adres_q, istek_adres_d;

    logic [CW-1:0]        bos_yer;
    logic                 istek_ver;
    logic                 yaz;
    logic                 oku;
    logic [GW-1:0]        bas_veri;

    // A pending request lives exactly one cycle; that cycle is the handoff.
    assign istek_ver  = istek_bekliyor_q;
    assign bos_yer    = CW'(DERINLIK) - doluluk_q;
    assign gc_hazir_c = istek_ver
                      | ((bos_yer >= CW'(KB_AYRILMIS_YER)) & ~istek_bekliyor_q);

    // Only an instruction the front end advanced to last cycle is new.
    assign yaz = on_buy_gecerli_g & hazir_onceki_q & ~istek_bekliyor_q & ~yonlendir_g;
    assign oku = coz.coz_gecerli_c & coz.coz_hazir_g & ~yonlendir_g;

    assign bb_buy_istek_c       = istek_bekliyor_q;
    assign bb_buy_istek_adres_c = istek_adres_q;

    assign coz.coz_gecerli_c = (doluluk_q != '0);
    assign coz.coz_buy_c     = bas_veri[GW-1:ADRES_BIT];
    assign coz.coz_ps_c      = bas_veri[ADRES_BIT-1:0];

    buyruk_kuyrugu_bellek #(
        .DERINLIK (DERINLIK),
        .GENISLIK (GW)
    ) u_bellek (
        .clk_g    (clk_g),
        .yaz_en   (yaz),
        .yaz_adr  (wr_ptr_q),
        .yaz_veri ({on_buy_g, on_buy_ps_g}),
        .oku_adr  (rd_ptr_q),
        .oku_veri (bas_veri)
    );

    // Next-state for occupancy, pointers and redirect bookkeeping.
    always_comb begin
        doluluk_d        = doluluk_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        hazir_onceki_d   = istek_ver ? 1'b0 : gc_hazir_c;
        istek_bekliyor_d = 1'b0;
        istek_adres_d    = istek_adres_q;

        if (yonlendir_g) begin
            doluluk_d        = '0;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            istek_bekliyor_d = 1'b1;
            istek_adres_d    = yonlendir_adres_g;
        end else begin
            if (yaz) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (oku) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({yaz, oku})
                2'b10:   doluluk_d = doluluk_q + CW'(1);
                2'b01:   doluluk_d = doluluk_q - CW'(1);
                default: doluluk_d = doluluk_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_g) begin
        if (!rst_n_g) begin
            doluluk_q        <= '0;
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            hazir_onceki_q   <= 1'b0;
            istek_bekliyor_q <= 1'b0;
            istek_adres_q    <= '0;
        end else begin
            doluluk_q        <= doluluk_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            hazir_onceki_q   <= hazir_onceki_d;
            istek_bekliyor_q <= istek_bekliyor_d;
            istek_adres_q    <= istek_adres_d;
        end
    end

endmodule
